mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the output mux.
REQ-002 Parameter SEL_BITS, default 2: select width; SHALL equal clog2(N), N >= 2.
REQ-003 Parameter DW, default 8: data width per requester.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  N  per-requester valid; held with data until granted.
REQ-007 data_in  input  N*DW  packed requester data; slice i = bits [i*DW +: DW].
REQ-008 gnt  output  N  one-hot, one-cycle pulse; data of that requester consumed this cycle.
REQ-009 sel  output  SEL_BITS  index of the requester currently owning out_data.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_data  output  DW  registered mux output.
REQ-012 out_ready  input  1  downstream accepts out_data when high with out_valid.

Function
REQ-013 FSM states IDLE (output register empty) and BUSY (output register full); no other states.
REQ-014 Load condition: (state==IDLE) or (out_valid && out_ready); arbitration happens only on load cycles with |req.
REQ-015 On load with |req: winner = first set req bit scanning from ptr upward, wrapping N-1 -> 0.
REQ-016 On that cycle gnt[winner]=1 (combinational, same cycle); next edge: out_data <= data_in[winner], sel <= winner, out_valid <= 1, ptr <= (winner+1) mod N, state BUSY.
REQ-017 gnt SHALL be all-zero on every non-load cycle and when req==0.
REQ-018 Load with req==0 from BUSY: out_valid <= 0, state IDLE; out_data and sel hold last value.
REQ-019 BUSY with out_ready=0: out_data, sel, out_valid, ptr stable; no gnt.
REQ-020 Throughput: back-to-back transfers with no bubble when out_ready held high and req continuous.
REQ-021 Latency: req asserted in IDLE -> gnt same cycle, out_valid next cycle.
REQ-022 Fairness: with all N requesting continuously and out_ready=1, each requester granted exactly once per N grants.
REQ-023 req dropped by a requester before gnt SHALL be permitted; it is simply not selected.

Reset
REQ-024 rst_n low: state IDLE, out_valid 0, out_data 0, sel 0, ptr 0, gnt 0, asynchronously.
REQ-025 Reset mid-transfer discards the held word; no gnt in the first cycle after release unless req is high and state is IDLE.

Configuration
REQ-026 Macro MUX_ARBITER_LOCK_EN adds input lock (N bits): lock[i] high with gnt[i] makes the next load grant requester i again if req[i] is high, ptr unchanged.
REQ-027 Lock SHALL release on the first load where req[i] is low or lock[i] was low at its last grant; then normal round-robin from ptr.
REQ-028 Without MUX_ARBITER_LOCK_EN: port lock absent, pure round-robin per REQ-015.

Structure
REQ-029 Package mux_arbiter_pkg: state enum (IDLE, BUSY), default parameter constants.
REQ-030 Sub-module rr_pick: combinational round-robin picker (req, ptr -> winner index, any); one instance.
REQ-031 Target size 120-400 lines RTL total.

Verification (N=4, DW=8)
REQ-032 Reset release, req=0 for 5 cycles -> out_valid=0, gnt=0, sel=0, out_data=0.
REQ-033 req=4'b0100, data_in slice 2=8'hA5, out_ready=1 -> gnt=4'b0100 at cycle 0; cycle 1 out_valid=1, sel=2, out_data=8'hA5; cycle 2 out_valid=0.
REQ-034 req=4'b1111 held, out_ready=1, slice i = 8'h10+i -> gnt sequence 0001,0010,0100,1000,0001; out_data 10,11,12,13,10 every cycle.
REQ-035 req=4'b0011, out_ready=0 for 4 cycles after first load -> single gnt 0001, out_data/sel stable; out_ready=1 -> gnt 0010 same cycle, sel=1 next.
REQ-036 Assert rst_n low while out_valid=1, sel=3 -> out_valid=0, sel=0, ptr=0 immediately; after release req=4'b1001 -> gnt 0001.
REQ-037 MUX_ARBITER_LOCK_EN: req=4'b0011, lock=4'b0001 for 3 grants -> gnt 0001 x3; lock=0 -> next gnt 0010.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter shared types and default sizes.
// Optional feature macro: MUX_ARBITER_LOCK_EN (grant lock).
package mux_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int N_DEF        = 4;
  localparam int SEL_BITS_DEF = 2;
  localparam int DW_DEF       = 8;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request at or above ptr, wrapping.
module rr_pick
  import mux_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_BITS = SEL_BITS_DEF
) (
  input  logic [N-1:0]        req,
  input  logic [SEL_BITS-1:0] ptr,
  output logic [SEL_BITS-1:0] idx,
  output logic                any
);

  int j;

  // Scan offsets high to low so the nearest hit to ptr wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx = SEL_BITS'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter feeding a registered output mux.
// Define MUX_ARBITER_LOCK_EN to add the per-requester lock input.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_BITS = SEL_BITS_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef MUX_ARBITER_LOCK_EN
  input  logic [N-1:0]        lock,
`endif
  input  logic [N-1:0]        req,
  input  logic [N*DW-1:0]     data_in,
  output logic [N-1:0]        gnt,
  output logic [SEL_BITS-1:0] sel,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  input  logic                out_ready
);

  state_e              state_q;
  logic                out_valid_q;
  logic [DW-1:0]       out_data_q;
  logic [SEL_BITS-1:0] sel_q;
  logic [SEL_BITS-1:0] ptr_q;
  logic [SEL_BITS-1:0] ptr_d;
  logic [SEL_BITS-1:0] pick_idx;
  logic [SEL_BITS-1:0] win;
  logic                pick_any;
  logic                load;
  logic                take;
  logic                hold;

  rr_pick #(
    .N        (N),
    .SEL_BITS (SEL_BITS)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Gated by rst_n so no grant leaks out while held in reset.
  assign load = rst_n &
                ((state_q == IDLE) |
                 (out_valid_q & out_ready));
  assign take = load & pick_any;

`ifdef MUX_ARBITER_LOCK_EN
  logic                lock_q;
  logic [SEL_BITS-1:0] lock_idx_q;

  assign hold = lock_q & req[lock_idx_q];
  assign win  = hold ? lock_idx_q : pick_idx;

  // Remember whether the last winner asked to keep ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (load) begin
      lock_q     <= take & lock[win];
      lock_idx_q <= win;
    end
  end
`else
  assign hold = 1'b0;
  assign win  = pick_idx;
`endif

  // Pointer moves one past the winner, wrapping at N-1.
  always_comb begin
    if (int'(win) == N - 1) ptr_d = '0;
    else                    ptr_d = win + 1'b1;
  end

  // One-hot grant pulse on the load cycle itself.
  always_comb begin
    gnt = '0;
    if (take) gnt[win] = 1'b1;
  end

  // Output register FSM: IDLE empty, BUSY holding a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      if (pick_any) begin
        state_q     <= BUSY;
        out_valid_q <= 1'b1;
        out_data_q  <= data_in[int'(win)*DW +: DW];
        sel_q       <= win;
        if (!hold) ptr_q <= ptr_d;
      end else begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (N=4, DW=8).
// Build with MUX_ARBITER_LOCK_EN to also exercise the lock input.
module tb_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
`ifdef MUX_ARBITER_LOCK_EN
  logic [3:0]  lock;
`endif

  int total = 0;
  int bad   = 0;

  int         m_ptr;
  int         m_sel;
  int         m_lidx;
  bit         m_full;
  bit         m_locked;
  logic [7:0] m_data;
  int         last_w;

  mux_arbiter #(
    .N        (4),
    .SEL_BITS (2),
    .DW       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MUX_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int rr(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_sel    = 0;
    m_lidx   = 0;
    m_full   = 1'b0;
    m_locked = 1'b0;
    m_data   = 8'h00;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step(input string nm);
    logic [3:0] eg;
    logic [3:0] lk_v;
    int         w;
    bit         ld;
    bit         lk;
    #1;
    ld = !m_full || (out_ready === 1'b1);
    w  = -1;
    lk = 1'b0;
    if (ld && req != 4'b0) begin
      if (m_locked && req[m_lidx]) begin
        w  = m_lidx;
        lk = 1'b1;
      end else begin
        w = rr(req, m_ptr);
      end
    end
    eg = (w >= 0) ? 4'(1 << w) : 4'b0;
    total++;
    if (gnt !== eg) begin
      bad++;
      $display("FAIL %s gnt got=%b exp=%b t=%0t",
               nm, gnt, eg, $time);
    end
    last_w = w;
`ifdef MUX_ARBITER_LOCK_EN
    lk_v = lock;
`else
    lk_v = 4'b0;
`endif
    @(posedge clk);
    if (ld) begin
      if (w >= 0) begin
        m_data   = data_in[w*8 +: 8];
        m_sel    = w;
        m_full   = 1'b1;
        if (!lk) m_ptr = (w + 1) % 4;
        m_locked = lk_v[w];
        m_lidx   = w;
      end else begin
        m_full   = 1'b0;
        m_locked = 1'b0;
      end
    end
    #1;
    total++;
    if (out_valid !== m_full || sel !== 2'(m_sel) ||
        out_data !== m_data) begin
      bad++;
      $display("FAIL %s out got=%b/%0d/%h exp=%b/%0d/%h",
               nm, out_valid, sel, out_data,
               m_full, m_sel, m_data);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'hF;
    data_in   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
`ifdef MUX_ARBITER_LOCK_EN
    lock      = 4'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (gnt !== 4'b0 || out_valid !== 1'b0 ||
        sel !== 2'd0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold got=%b/%b/%0d/%h exp=0",
               gnt, out_valid, sel, out_data);
    end
    @(negedge clk);
    req   = 4'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle_after_reset");
  endtask

  task automatic test_single();
    do_reset();
    data_in          = $urandom;
    data_in[16 +: 8] = 8'hA5;
    req              = 4'b0100;
    out_ready        = 1'b1;
    step("single_load");
    req = 4'b0;
    step("single_drain");
  endtask

  task automatic test_rr();
    do_reset();
    for (int i = 0; i < 4; i++)
      data_in[i*8 +: 8] = 8'(8'h10 + i);
    req       = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("rr_full");
  endtask

  task automatic test_stall();
    do_reset();
    data_in   = $urandom;
    req       = 4'b0011;
    out_ready = 1'b1;
    step("stall_first");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = $urandom;
      step("stall_hold");
    end
    out_ready = 1'b1;
    step("stall_release");
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_in   = $urandom;
    req       = 4'b1000;
    out_ready = 1'b1;
    step("mid_load3");
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || sel !== 2'd0 ||
        out_data !== 8'h00 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%0d/%h/%b exp=0",
               out_valid, sel, out_data, gnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req       = 4'b1001;
    out_ready = 1'b1;
    step("mid_after");
  endtask

  task automatic test_fair();
    int cnt [4];
    do_reset();
    req       = 4'hF;
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int i = 0; i < 4; i++) begin
        data_in = $urandom;
        step("fair_step");
        if (gnt_seen(last_w)) cnt[last_w]++;
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cnt[i] != 1) begin
          bad++;
          $display("FAIL fair_count req%0d got=%0d exp=1",
                   i, cnt[i]);
        end
      end
    end
  endtask

  function automatic bit gnt_seen(int w);
    return w >= 0 && w < 4;
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req       = 4'($urandom_range(0, 15));
      data_in   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUX_ARBITER_LOCK_EN
      lock      = 4'($urandom_range(0, 15));
`endif
      step("random");
    end
`ifdef MUX_ARBITER_LOCK_EN
    lock = 4'b0;
`endif
  endtask

`ifdef MUX_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    req       = 4'b0011;
    out_ready = 1'b1;
    lock      = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      data_in = $urandom;
      step("lock_hold");
    end
    lock    = 4'b0000;
    data_in = $urandom;
    step("lock_last");
    data_in = $urandom;
    step("lock_release");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_reset_mid();
    test_fair();
`ifdef MUX_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
